pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. Each cycle it produces the load-enable, flush and valid-injection controls for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB stage registers. It resolves load-use hazards, taken branches/jumps, instruction-fetch misses and multi-cycle data-memory accesses. It also times out hung data-memory accesses and keeps a saturating stall-cycle counter.

## Interface
- DMEM_TIMEOUT, 64: consecutive data-memory stall cycles before fault; 0 disables the timeout.
- CNT_W, 32: width of the performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_rs1_addr  in  5  rs1 of the instruction in ID.
- id_rs2_addr  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd_addr  in  5  rd of the instruction in EX.
- ex_is_load  in  1  EX instruction is a valid load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump; the PC mux selects the target.
- ic_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM-stage instruction is a valid load/store.
- dmem_ack  in  1  data memory completes the access this cycle.
- ex_mem_valid  in  1  valid bit currently held in EX_MEM.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (valid=0) instead of data.
- mem_wb_valid_in  out  1  valid written into MEM_WB.
- dmem_fault  out  1  sticky timeout flag.
- state  out  2  FSM state: RUN=0, MEM_WAIT=1, FAULT=2.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating.

## Operation
- mem_stall = dmem_req & ~dmem_ack.
- load_use = ex_is_load & ex_rd_addr≠0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- Combinational controls, first matching rule wins:
  - FAULT state: all enables 0, flushes 0, mem_wb_valid_in=0.
  - mem_stall: pc_en=if_id_en=id_ex_en=ex_mem_en=0; flushes 0; mem_wb_valid_in=0, so WB sees a bubble and everything upstream freezes.
  - ex_branch_taken: all enables 1, if_id_flush=id_ex_flush=1. This rule overrides load_use and a fetch miss.
  - load_use: pc_en=if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1.
  - ~ic_ready: pc_en=0, if_id_en=1, if_id_flush=1, remaining enables 1.
  - Otherwise: all enables 1, flushes 0.
- mem_wb_valid_in = ex_mem_valid & ~mem_stall in all states except FAULT, where it is 0.
- FSM:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN on dmem_ack or when dmem_req deasserts.
  - MEM_WAIT→FAULT when mem_stall holds and wait_cnt==DMEM_TIMEOUT-1 (DMEM_TIMEOUT≠0).
  - FAULT is left only by rst.
- wait_cnt:
  - Loads 1 on RUN→MEM_WAIT.
  - Increments each stalled cycle in MEM_WAIT.
  - Clears in RUN.
  - Its width is sized to hold DMEM_TIMEOUT.
- dmem_fault = (state==FAULT).
- stall_cycles increments on every cycle with pc_en=0, including FAULT, and holds at all-ones.

## Timing
- Reset values: state=RUN, wait_cnt=0, stall_cycles=0, dmem_fault=0.
- During rst, the combinational outputs follow the RUN rules from the inputs.
- All controls are combinational from the current inputs and state, with zero latency. The stage registers sample them on the same clk edge.
- With DMEM_TIMEOUT=N: for an access with ack never arriving, the first stall cycle is in RUN, and cycles 2..N are in MEM_WAIT. state=FAULT and dmem_fault=1 are visible from the edge after the Nth stalled cycle.
- If ack arrives in the Nth stalled cycle, the access completes normally and there is no fault.
- Branch during mem_stall: no flush, because EX is frozen. The flush fires in the first unstalled cycle, since ex_branch_taken is still presented.
- A load-use hazard lasts exactly one cycle per hazard, because the bubble enters EX.
- Reset mid-stall returns to RUN at once, with counters cleared.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1. stall_cycles goes 0→1. The next cycle is all-enable.
- ex_rd=0 with a matching rs1=0 -> no stall. rs2 match with id_uses_rs2=0 -> no stall.
- Branch + load_use + ic_ready=0 in the same cycle -> all enables 1, if_id_flush=id_ex_flush=1.
- dmem_req=1, ack on the 3rd cycle, ex_mem_valid=1 -> 2 frozen cycles with mem_wb_valid_in=0, state RUN,MEM_WAIT,RUN, then mem_wb_valid_in=1. stall_cycles=2.
- DMEM_TIMEOUT=4, ack never arrives -> state=FAULT after the 4th stalled cycle, dmem_fault=1, all enables 0. Repeat with ack in the 4th cycle -> no fault.
- Async rst asserted mid-MEM_WAIT -> immediately state=0, stall_cycles=0, dmem_fault=0. Saturation check: CNT_W=3, 9 stall cycles -> stall_cycles=7.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard/control bundle between the RV32 pipeline datapath and its stall/flush sequencer.
// The datapath side is the master; the sequencer is the slave.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_is_load;
  logic             ex_branch_taken;
  logic             ic_ready;
  logic             dmem_req;
  logic             dmem_ack;
  logic             ex_mem_valid;

  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_valid_in;
  logic             dmem_fault;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_is_load, ex_branch_taken, ic_ready, dmem_req, dmem_ack, ex_mem_valid,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_valid_in, dmem_fault, state, stall_cycles
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_is_load, ex_branch_taken, ic_ready, dmem_req, dmem_ack, ex_mem_valid,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_valid_in, dmem_fault, state, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: hazard priority, data-memory
// wait FSM with timeout fault, and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam int WAIT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q;

  logic mem_stall, load_use;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;

  assign mem_stall = bus.dmem_req & ~bus.dmem_ack;
  assign load_use  = bus.ex_is_load & (bus.ex_rd_addr != 5'd0) &
                     ((bus.id_uses_rs1 & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                      (bus.id_uses_rs2 & (bus.id_rs2_addr == bus.ex_rd_addr)));

  // Priority: fault, memory freeze, redirect, load-use bubble, fetch miss.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (state_q == FAULT || mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (bus.ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!bus.ic_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // A timeout of one stalled cycle has no MEM_WAIT phase, so RUN faults directly.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      RUN: begin
        wait_d = '0;
        if (mem_stall) begin
          if (DMEM_TIMEOUT == 1) begin
            state_d = FAULT;
          end else begin
            state_d = MEM_WAIT;
            wait_d  = WAIT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (DMEM_TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pc_en) stall_q <= sat_inc(stall_q);
    end
  end

  assign bus.pc_en           = pc_en;
  assign bus.if_id_en        = if_id_en;
  assign bus.id_ex_en        = id_ex_en;
  assign bus.ex_mem_en       = ex_mem_en;
  assign bus.if_id_flush     = if_id_flush;
  assign bus.id_ex_flush     = id_ex_flush;
  assign bus.mem_wb_valid_in = (state_q != FAULT) & bus.ex_mem_valid & ~mem_stall;
  assign bus.dmem_fault      = (state_q == FAULT);
  assign bus.state           = state_q;
  assign bus.stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: two instances (timeout 4 / 32-bit counter, and
// timeout disabled / 3-bit counter) share stimulus and are checked against a cycle model.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       u1;
    logic       u2;
    logic       ld;
    logic       br;
    logic       icr;
    logic       req;
    logic       ack;
    logic       emv;
  } stim_t;

  typedef struct packed {
    logic [6:0]  ctrl_a;
    logic [6:0]  ctrl_b;
    logic [1:0]  st_a;
    logic [1:0]  st_b;
    logic        flt_a;
    logic        flt_b;
    logic [31:0] cnt_a;
    logic [2:0]  cnt_b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(32)) bus_a ();
  pipeline_ctrl_if #(.CNT_W(3))  bus_b ();

  pipeline_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  pipeline_ctrl #(.DMEM_TIMEOUT(0), .CNT_W(3))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // Reference model state, index 0 = dut_a, 1 = dut_b
  bit              m_fault[2];
  bit              m_prev[2];
  int              m_run[2];
  longint unsigned m_cnt[2];
  int              tmo[2]  = '{4, 0};
  longint unsigned cmax[2] = '{64'hFFFF_FFFF, 64'd7};

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Outputs as {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_valid_in}
  function automatic logic [6:0] ctrl_model(input stim_t s, input bit fault);
    bit ms, lu;
    ms = s.req && !s.ack;
    lu = s.ld && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (fault || ms)  return 7'b0000000;
    if (s.br)         return {6'b111111, s.emv};
    if (lu)           return {6'b001101, s.emv};
    if (!s.icr)       return {6'b011110, s.emv};
    return {6'b111100, s.emv};
  endfunction

  task automatic apply(input stim_t s);
    bus_a.id_rs1_addr = s.rs1;  bus_b.id_rs1_addr = s.rs1;
    bus_a.id_rs2_addr = s.rs2;  bus_b.id_rs2_addr = s.rs2;
    bus_a.id_uses_rs1 = s.u1;   bus_b.id_uses_rs1 = s.u1;
    bus_a.id_uses_rs2 = s.u2;   bus_b.id_uses_rs2 = s.u2;
    bus_a.ex_rd_addr  = s.rd;   bus_b.ex_rd_addr  = s.rd;
    bus_a.ex_is_load  = s.ld;   bus_b.ex_is_load  = s.ld;
    bus_a.ex_branch_taken = s.br; bus_b.ex_branch_taken = s.br;
    bus_a.ic_ready    = s.icr;  bus_b.ic_ready    = s.icr;
    bus_a.dmem_req    = s.req;  bus_b.dmem_req    = s.req;
    bus_a.dmem_ack    = s.ack;  bus_b.dmem_ack    = s.ack;
    bus_a.ex_mem_valid = s.emv; bus_b.ex_mem_valid = s.emv;
  endtask

  task automatic cyc(input stim_t s, input bit r);
    exp_t e;
    logic [6:0] cc[2];
    logic [1:0] st[2];
    bit ms;
    @(posedge clk);
    #1;
    rst = r;
    apply(s);
    ms = s.req && !s.ack;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_fault[i] = 0; m_prev[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
      end
      cc[i] = ctrl_model(s, m_fault[i]);
      st[i] = m_fault[i] ? 2'd2 : (m_prev[i] ? 2'd1 : 2'd0);
    end
    e.ctrl_a = cc[0];  e.ctrl_b = cc[1];
    e.st_a   = st[0];  e.st_b   = st[1];
    e.flt_a  = m_fault[0]; e.flt_b = m_fault[1];
    e.cnt_a  = 32'(m_cnt[0]);
    e.cnt_b  = 3'(m_cnt[1]);
    sb.push_back(e);
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        if (!cc[i][6] && m_cnt[i] < cmax[i]) m_cnt[i]++;
        if (!m_fault[i]) begin
          if (ms) begin
            m_run[i]++;
            if (tmo[i] != 0 && m_run[i] == tmo[i]) m_fault[i] = 1;
          end else begin
            m_run[i] = 0;
          end
          m_prev[i] = ms;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("ctrl_a", 64'({bus_a.pc_en, bus_a.if_id_en, bus_a.id_ex_en, bus_a.ex_mem_en,
                           bus_a.if_id_flush, bus_a.id_ex_flush, bus_a.mem_wb_valid_in}), 64'(e.ctrl_a));
      check("ctrl_b", 64'({bus_b.pc_en, bus_b.if_id_en, bus_b.id_ex_en, bus_b.ex_mem_en,
                           bus_b.if_id_flush, bus_b.id_ex_flush, bus_b.mem_wb_valid_in}), 64'(e.ctrl_b));
      check("state_a", 64'(bus_a.state), 64'(e.st_a));
      check("state_b", 64'(bus_b.state), 64'(e.st_b));
      check("fault_a", 64'(bus_a.dmem_fault), 64'(e.flt_a));
      check("fault_b", 64'(bus_b.dmem_fault), 64'(e.flt_b));
      check("stall_cycles_a", 64'(bus_a.stall_cycles), 64'(e.cnt_a));
      check("stall_cycles_b", 64'(bus_b.stall_cycles), 64'(e.cnt_b));
    end
  end

  initial begin
    stim_t idle, s, stl;
    idle = '{rs1:5'd1, rs2:5'd2, rd:5'd3, u1:1'b0, u2:1'b0, ld:1'b0, br:1'b0,
             icr:1'b1, req:1'b0, ack:1'b0, emv:1'b1};
    stl = idle; stl.req = 1'b1; stl.ack = 1'b0;
    rst = 1'b1;
    apply(idle);

    cyc(idle, 1); cyc(idle, 1);

    // load-use on rs1, then clean cycles
    s = idle; s.ld = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
    cyc(s, 0); cyc(idle, 0); cyc(idle, 0);
    // x0 never hazards; unused rs2 match never hazards
    s = idle; s.ld = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
    cyc(s, 0);
    s = idle; s.ld = 1; s.rd = 6; s.rs2 = 6; s.u2 = 0;
    cyc(s, 0);
    // branch overrides load-use and fetch miss
    s = idle; s.br = 1; s.ld = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1; s.icr = 0;
    cyc(s, 0);
    s = idle; s.icr = 0;
    cyc(s, 0);

    // two-cycle memory wait, ack in third
    cyc(idle, 1);
    cyc(stl, 0); cyc(stl, 0);
    s = stl; s.ack = 1; cyc(s, 0);
    cyc(idle, 0);

    // branch held through a memory stall flushes once the stall ends
    s = stl; s.br = 1; cyc(s, 0); cyc(s, 0);
    s.ack = 1; cyc(s, 0);
    cyc(idle, 0);

    // hung access: timeout fault on dut_a, saturation on dut_b
    cyc(idle, 1);
    repeat (9) cyc(stl, 0);
    cyc(idle, 0);
    @(negedge clk);
    check("sat_b_is_7", 64'(bus_b.stall_cycles), 64'd7);
    check("timeout_fault_a", 64'({bus_a.dmem_fault, bus_a.state, bus_a.pc_en, bus_a.ex_mem_en}), 64'b1_10_0_0);

    // ack in the 4th stalled cycle completes normally
    cyc(idle, 1);
    repeat (3) cyc(stl, 0);
    s = stl; s.ack = 1; cyc(s, 0);
    cyc(idle, 0);
    @(negedge clk);
    check("no_fault_ack4", 64'({bus_a.dmem_fault, bus_a.state}), 64'b0_00);

    // async reset in the middle of MEM_WAIT
    cyc(idle, 1);
    cyc(stl, 0); cyc(stl, 0);
    cyc(stl, 1);
    cyc(idle, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom);
      s.u2  = 1'($urandom);
      s.ld  = 1'($urandom);
      s.br  = ($urandom_range(0, 7) == 0);
      s.icr = ($urandom_range(0, 4) != 0);
      s.req = 1'($urandom);
      s.ack = ($urandom_range(0, 9) < 4);
      s.emv = 1'($urandom);
      cyc(s, $urandom_range(0, 39) == 0);
    end
    cyc(idle, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
